// File: rtl/recolector_egreso.sv
// Egress collector: drains four FWFT output FIFOs with work-conserving
// round-robin arbitration, merges them into one registered stream and keeps
// delivered-word counters with a req/idx readback port.
module recolector_egreso #(
    parameter int TAMANO_DATOS = 12,
    parameter int CONT_ANCHO   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              empty,
    input  logic [TAMANO_DATOS-1:0] data_in0,
    input  logic [TAMANO_DATOS-1:0] data_in1,
    input  logic [TAMANO_DATOS-1:0] data_in2,
    input  logic [TAMANO_DATOS-1:0] data_in3,
    input  logic                    almost_full_dest,
    input  logic                    req,
    input  logic [2:0]              idx,
    output logic [3:0]              pop,
    output logic [TAMANO_DATOS-1:0] data_out,
    output logic                    valid_out,
    output logic [CONT_ANCHO-1:0]   cnt_data,
    output logic                    cnt_valid,
    output logic                    idle
);

    localparam logic [CONT_ANCHO-1:0] CNT_ONE = {{(CONT_ANCHO-1){1'b0}}, 1'b1};

    logic [TAMANO_DATOS-1:0] head [4];
    assign head[0] = data_in0;
    assign head[1] = data_in1;
    assign head[2] = data_in2;
    assign head[3] = data_in3;

    // Round-robin pointer: index of the most recently granted FIFO.
    logic [1:0]              last_q, last_d;
    logic [TAMANO_DATOS-1:0] data_out_q, data_out_d;
    logic                    valid_out_q, valid_out_d;
    logic [CONT_ANCHO-1:0]   cnt_q [4];
    logic [CONT_ANCHO-1:0]   cnt_d [4];
    logic [CONT_ANCHO-1:0]   tot_q, tot_d;
    logic [CONT_ANCHO-1:0]   cnt_data_q, cnt_data_d;
    logic                    cnt_valid_q, cnt_valid_d;
    logic                    idle_q, idle_d;

    logic                    gnt_vld;
    logic [1:0]              gnt_idx;
    logic [1:0]              cand;

    // Grant search: first non-empty FIFO after last, wrapping modulo 4.
    // Reset is folded in so no pop escapes while the block is held in reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        cand    = last_q;
        if (reset && !almost_full_dest) begin
            for (int k = 1; k <= 4; k++) begin
                cand = last_q + k[1:0];
                if (!gnt_vld && !empty[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    // One-hot pop strobe straight from the grant.
    always_comb begin
        pop = 4'b0000;
        if (gnt_vld) pop[gnt_idx] = 1'b1;
    end

    // Next-state for the output stage, counters, readback and idle flag.
    always_comb begin
        last_d      = last_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        tot_d       = tot_q;
        for (int n = 0; n < 4; n++) cnt_d[n] = cnt_q[n];
        if (gnt_vld) begin
            last_d         = gnt_idx;
            data_out_d     = head[gnt_idx];
            valid_out_d    = 1'b1;
            cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNT_ONE;
            tot_d          = tot_q + CNT_ONE;
        end

        // Readback samples the pre-increment value; reserved selects read 0.
        cnt_data_d  = cnt_data_q;
        cnt_valid_d = 1'b0;
        if (req) begin
            cnt_valid_d = 1'b1;
            case (idx)
                3'd0, 3'd1, 3'd2, 3'd3: cnt_data_d = cnt_q[idx[1:0]];
                3'd4:                   cnt_data_d = tot_q;
                default:                cnt_data_d = '0;
            endcase
        end

        idle_d = (empty == 4'b1111) && !valid_out_d;
    end

    // State registers; an asserted reset drops any in-flight word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q      <= 2'd3;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            tot_q       <= '0;
            for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
            cnt_data_q  <= '0;
            cnt_valid_q <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            last_q      <= last_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            tot_q       <= tot_d;
            for (int n = 0; n < 4; n++) cnt_q[n] <= cnt_d[n];
            cnt_data_q  <= cnt_data_d;
            cnt_valid_q <= cnt_valid_d;
            idle_q      <= idle_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign cnt_data  = cnt_data_q;
    assign cnt_valid = cnt_valid_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_recolector_egreso.sv
// Bench for recolector_egreso: emulates the four FWFT FIFOs with queues,
// predicts every output from a queue-level model and checks each cycle,
// plus literal expectations for the directed scenarios.
module tb_recolector_egreso;

    localparam int W  = 12;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    empty;
    logic [W-1:0]  data_in0, data_in1, data_in2, data_in3;
    logic          almost_full_dest;
    logic          req;
    logic [2:0]    idx;
    logic [3:0]    pop;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic [CW-1:0] cnt_data;
    logic          cnt_valid;
    logic          idle;

    always #5 clk = ~clk;

    recolector_egreso #(.TAMANO_DATOS(W), .CONT_ANCHO(CW)) dut (
        .clk(clk), .reset(reset), .empty(empty),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .almost_full_dest(almost_full_dest), .req(req), .idx(idx),
        .pop(pop), .data_out(data_out), .valid_out(valid_out),
        .cnt_data(cnt_data), .cnt_valid(cnt_valid), .idle(idle)
    );

    // FIFO contents
    logic [W-1:0] q0[$], q1[$], q2[$], q3[$];

    // Model state
    int           m_last;
    logic [W-1:0] m_dout;
    bit           m_valid;
    int           m_cnt [5];
    int           m_cdata;
    bit           m_cvalid;
    bit           m_idle;

    int n_err = 0;
    int n_chk = 0;

    logic [3:0]   pop_log[$];
    logic [W-1:0] dout_log[$];
    bit           vld_log[$];
    bit           idle_log[$];

    function automatic int fsize(int n);
        case (n)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [W-1:0] ffront(int n);
        case (n)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic fpop(int n);
        case (n)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic fpush(int n, logic [W-1:0] v);
        case (n)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic fclear();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic clear_logs();
        pop_log.delete(); dout_log.delete(); vld_log.delete(); idle_log.delete();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which FIFO the spec says is granted now (-1 = none).
    function automatic int exp_grant();
        if (!reset || almost_full_dest) return -1;
        for (int k = 1; k <= 4; k++) begin
            int n;
            n = (m_last + k) % 4;
            if (fsize(n) > 0) return n;
        end
        return -1;
    endfunction

    function automatic int sel_cnt(int s);
        if (s < 5) return m_cnt[s];
        return 0;
    endfunction

    task automatic model_reset();
        m_last   = 3;
        m_dout   = '0;
        m_valid  = 0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_cdata  = 0;
        m_cvalid = 0;
        m_idle   = 1;
    endtask

    task automatic drive();
        for (int n = 0; n < 4; n++) empty[n] = (fsize(n) == 0);
        data_in0 = (q0.size() > 0) ? q0[0] : 12'h5A5;
        data_in1 = (q1.size() > 0) ? q1[0] : 12'hA5A;
        data_in2 = (q2.size() > 0) ? q2[0] : 12'h3C3;
        data_in3 = (q3.size() > 0) ? q3[0] : 12'hC3C;
    endtask

    task automatic check();
        int g;
        int ep;
        g  = exp_grant();
        ep = (g < 0) ? 0 : (1 << g);
        chk("pop", int'(pop), ep);
        chk("valid_out", int'(valid_out), int'(m_valid));
        chk("data_out", int'(data_out), int'(m_dout));
        chk("cnt_valid", int'(cnt_valid), int'(m_cvalid));
        chk("cnt_data", int'(cnt_data), m_cdata);
        chk("idle", int'(idle), int'(m_idle));
        pop_log.push_back(pop);
        dout_log.push_back(data_out);
        vld_log.push_back(valid_out);
        idle_log.push_back(idle);
    endtask

    // Model advance at the clock edge, using the inputs the DUT samples.
    task automatic update();
        int  g;
        bit  all_empty;
        if (!reset) begin
            model_reset();
            return;
        end
        g = exp_grant();
        all_empty = (fsize(0) == 0) && (fsize(1) == 0) && (fsize(2) == 0) && (fsize(3) == 0);
        if (req) begin
            m_cdata  = sel_cnt(int'(idx));
            m_cvalid = 1;
        end else begin
            m_cvalid = 0;
        end
        m_idle = all_empty && (g < 0);
        if (g >= 0) begin
            m_dout   = ffront(g);
            m_valid  = 1;
            m_last   = g;
            m_cnt[g] = (m_cnt[g] + 1) % 32;
            m_cnt[4] = (m_cnt[4] + 1) % 32;
            fpop(g);
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic cyc();
        drive();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    // Asserts reset just after an edge and checks the async clear at once.
    task automatic do_reset(input bit clr);
        reset = 1'b0;
        #1;
        chk("rst_pop", int'(pop), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_cnt_data", int'(cnt_data), 0);
        chk("rst_cnt_valid", int'(cnt_valid), 0);
        model_reset();
        if (clr) fclear();
        cyc();
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (fsize(0) + fsize(1) + fsize(2) + fsize(3) == 0) break;
            cyc();
        end
        cyc(); cyc();
    endtask

    initial begin
        logic [3:0]   rr_pop [5];
        logic [W-1:0] rr_dat [5];
        logic [3:0]   bp_pop [7];
        logic [3:0]   me_pop [7];

        rr_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dat = '{12'h100, 12'h200, 12'h300, 12'hC00, 12'h101};
        bp_pop = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
        me_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};

        reset = 1'b0;
        almost_full_dest = 1'b0;
        req = 1'b0;
        idx = 3'd0;
        model_reset();
        drive();
        @(posedge clk); #1;
        do_reset(1);
        reset = 1'b1;
        cyc(); cyc();
        chk("idle_after_reset", int'(idle), 1);

        // Reset mid-stream with FIFO 2 holding data.
        for (int i = 0; i < 3; i++) fpush(2, 12'h700 + 12'(i));
        cyc();
        do_reset(0);
        cyc();
        fclear();
        fpush(0, 12'h011); fpush(2, 12'h022);
        reset = 1'b1;
        clear_logs();
        cyc(); cyc(); cyc();
        chk("first_grant_after_reset", int'(pop_log[0]), 1);
        chk("second_grant_after_reset", int'(pop_log[1]), 4);
        drain();

        // Round-robin with all four FIFOs busy.
        do_reset(1);
        fpush(0, 12'h100); fpush(0, 12'h101);
        fpush(1, 12'h200); fpush(1, 12'h201);
        fpush(2, 12'h300); fpush(2, 12'h301);
        fpush(3, 12'hC00); fpush(3, 12'hC01);
        reset = 1'b1;
        clear_logs();
        for (int i = 0; i < 6; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            chk("rr_pop", int'(pop_log[i]), int'(rr_pop[i]));
            chk("rr_data", int'(dout_log[i+1]), int'(rr_dat[i]));
            chk("rr_valid", int'(vld_log[i+1]), 1);
        end
        drain();

        // Single queue: FIFO 3 with five words.
        do_reset(1);
        for (int i = 0; i < 5; i++) fpush(3, 12'hE40 + 12'(i));
        reset = 1'b1;
        clear_logs();
        for (int i = 0; i < 7; i++) cyc();
        for (int i = 0; i < 5; i++) chk("single_pop", int'(pop_log[i]), 8);
        chk("single_pop_end", int'(pop_log[5]), 0);
        for (int i = 1; i <= 5; i++) chk("single_valid", int'(vld_log[i]), 1);
        chk("single_valid_end", int'(vld_log[6]), 0);
        req = 1'b1; idx = 3'd3;
        cyc();
        req = 1'b0;
        chk("single_cnt3", int'(cnt_data), 5);
        chk("single_cnt3_valid", int'(cnt_valid), 1);
        cyc();

        // Backpressure for three cycles during streaming.
        do_reset(1);
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 4; i++) fpush(n, 12'((n + 1) * 12'h100 + i));
        reset = 1'b1;
        clear_logs();
        cyc(); cyc();
        almost_full_dest = 1'b1;
        cyc(); cyc(); cyc();
        almost_full_dest = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 7; i++) chk("bp_pop", int'(pop_log[i]), int'(bp_pop[i]));
        chk("bp_inflight_valid", int'(vld_log[2]), 1);
        chk("bp_inflight_data", int'(dout_log[2]), 12'h200);
        for (int i = 3; i <= 5; i++) chk("bp_gap_valid", int'(vld_log[i]), 0);
        chk("bp_resume_valid", int'(vld_log[6]), 1);
        drain();

        // Counter wrap, same-edge read and reserved index.
        do_reset(1);
        for (int i = 0; i < 33; i++) fpush(1, 12'(i));
        reset = 1'b1;
        drain();
        req = 1'b1; idx = 3'd1; cyc();
        chk("wrap_cnt1", int'(cnt_data), 1);
        idx = 3'd4; cyc();
        chk("wrap_total", int'(cnt_data), 1);
        idx = 3'd6; cyc();
        chk("reserved_idx", int'(cnt_data), 0);
        chk("reserved_valid", int'(cnt_valid), 1);
        fpush(1, 12'h3FF);
        idx = 3'd1; cyc();
        chk("same_edge_pre", int'(cnt_data), 1);
        cyc();
        chk("same_edge_post", int'(cnt_data), 2);
        req = 1'b0;
        cyc();
        chk("cnt_valid_drop", int'(cnt_valid), 0);

        // FIFO 1 empties while 0 and 2 keep data.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            fpush(0, 12'h0A0 + 12'(i));
            fpush(2, 12'h2A0 + 12'(i));
        end
        fpush(1, 12'h1A0);
        reset = 1'b1;
        clear_logs();
        for (int i = 0; i < 10; i++) cyc();
        for (int i = 0; i < 7; i++) chk("me_pop", int'(me_pop[i]), int'(pop_log[i]));
        for (int i = 1; i <= 7; i++) chk("me_idle_busy", int'(idle_log[i]), 0);
        chk("me_last_valid", int'(vld_log[7]), 1);
        chk("me_idle_back", int'(idle_log[8]), 1);

        // Randomized traffic, backpressure, reads and occasional resets.
        do_reset(1);
        reset = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < 4; n++)
                if ($urandom_range(0, 9) < 3 && fsize(n) < 8) fpush(n, 12'($urandom));
            almost_full_dest = ($urandom_range(0, 3) == 0);
            req = ($urandom_range(0, 2) == 0);
            idx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
                reset = 1'b1;
            end else begin
                cyc();
            end
        end
        almost_full_dest = 1'b0;
        req = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/recolector_egreso.md
Name: recolector_egreso

Overview:
- Egress collector at the far end of the switch. It drains the four output VC FIFOs (destinations 0-3) and merges them into one registered stream towards the link or downstream sink.
- Generates the four pop strobes that the bench probe drives today, using work-conserving round-robin arbitration gated by downstream backpressure.
- Keeps per-destination and total delivered-word counters, read back through a req/idx handshake.

Parameters:
TAMANO_DATOS, 12, word width (bits [11:10] class, [9:8] dest, [7:0] payload)
CONT_ANCHO, 5, width of each delivered-word counter

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
empty  input  4  empty flags of output FIFOs 0-3 (bit N = FIFO N)
data_in0  input  TAMANO_DATOS  head word of FIFO 0
data_in1  input  TAMANO_DATOS  head word of FIFO 1
data_in2  input  TAMANO_DATOS  head word of FIFO 2
data_in3  input  TAMANO_DATOS  head word of FIFO 3
almost_full_dest  input  1  downstream cannot accept more than one further word
req  input  1  counter read request
idx  input  3  counter select: 0-3 per destination, 4 total, 5-7 reserved
pop  output  4  one-hot pop strobes to FIFOs 0-3
data_out  output  TAMANO_DATOS  merged output word
valid_out  output  1  data_out valid this cycle
cnt_data  output  CONT_ANCHO  counter readback value
cnt_valid  output  1  cnt_data valid this cycle
idle  output  1  nothing pending anywhere

Behaviour:
- Reset (reset=0, async):
  - pop=0, data_out=0, valid_out=0, cnt_data=0, cnt_valid=0.
  - idle=1 once reset is released and all FIFOs are empty.
  - All counters cleared. Round-robin pointer last=3, so FIFO 0 has first priority.
  - Reset asserted mid-transfer drops any in-flight word. No pop is issued while reset=0.
- Head words are first-word-fall-through: data_inN is valid whenever empty[N]=0. A pop in cycle T consumes the word presented in cycle T.
- Arbitration, combinational within cycle T:
  - If almost_full_dest=0 and empty!=4'b1111, grant the first non-empty FIFO scanning last+1, last+2, ... modulo 4.
  - pop = onehot(grant). At most one pop bit is ever high.
  - Otherwise pop=0.
- On each clock edge with a grant:
  - last <= grant.
  - data_out <= data_in[grant], valid_out <= 1.
  - Output latency is 1 cycle from pop.
- Without a grant: valid_out <= 0 and data_out holds its last value.
- Backpressure:
  - almost_full_dest is sampled in the same cycle as the pop decision.
  - The single in-flight word is always delivered, so the sink's almost_full margin must be at least 1 entry.
- Work conserving: a FIFO going empty never stalls the other queues. A single non-empty FIFO can be popped every cycle.
- Fairness: with all four FIFOs continuously non-empty, the grant order is 0,1,2,3,0,... No FIFO waits more than 3 grants.
- Counters:
  - cnt[N] increments on each pop[N]. cnt_total increments on any pop.
  - All counters wrap modulo 2^CONT_ANCHO (31 -> 0).
- Readback:
  - req=1 at edge T loads cnt_data with the selected counter value before any increment at that same edge, and sets cnt_valid=1 for one cycle.
  - idx 5-7 return 0 with cnt_valid=1.
  - req held high gives a fresh read every cycle.
- idle = (empty==4'b1111) && !valid_out, registered. It drops the cycle after any FIFO becomes non-empty.
- The class and dest fields are not inspected. Data passes through unaltered.

Test Plan:
- Reset check: drive reset=0 mid-stream with FIFO 2 non-empty -> pop=0, valid_out=0, cnt_data=0 immediately. After release the first grant goes to FIFO 0 if it is non-empty.
- Round-robin: all FIFOs non-empty with heads 0x100, 0x200, 0x300, 0xC00 -> pop sequence 0001, 0010, 0100, 1000, 0001. data_out follows the same order one cycle later, with valid_out high continuously.
- Single queue: only FIFO 3 holds 5 words and the rest are empty -> pop=1000 for 5 consecutive cycles, then 0. valid_out is high for 5 cycles, and idx=3 reads back 5.
- Backpressure: almost_full_dest=1 for 3 cycles during streaming -> pop=0 in exactly those cycles. The word popped before assertion still appears with valid_out=1, and arbitration resumes at the next FIFO in order.
- Counter wrap and same-edge read: 33 pops from FIFO 1 -> idx=1 reads 1 and idx=4 reads 1. A req on the same edge as a pop returns the pre-increment value. idx=6 returns 0 with cnt_valid=1.
- Mid-stream empty: FIFO 1 goes empty while 0 and 2 have data -> grants skip 1 (0, 2, 0, 2). idle=0 throughout, and idle=1 one cycle after the last valid_out.
